// File: rtl/int_issue_sched.sv
// int_issue_sched: oldest-first integer issue scheduler with FU tracking, kill handling and wakeups (DIV_EARLY_WAKEUP_EN: DIV wakeup one cycle early)
module int_issue_sched #(
  parameter int REQ     = 4,
  parameter int PRF_W   = 7,
  parameter int SPEC    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      Kill_Enable,
  input  logic                      Update_KillMask,
  input  logic [SPEC-1:0]           FUBR_SpecTag,
  input  logic [REQ-1:0]            Req_Valid,
  input  logic [2*REQ-1:0]          Req_FuType,
  input  logic [REQ-1:0]            Req_RegWe,
  input  logic [REQ-1:0]            Req_RdType,
  input  logic [REQ*PRF_W-1:0]      Req_Prd,
  input  logic [REQ*SPEC-1:0]       Req_KillMask,
  output logic [REQ-1:0]            Issued_Valid,
  output logic [3:0]                FU_Issue_Valid,
  output logic [4*$clog2(REQ)-1:0]  FU_Issue_Idx,
  output logic                      Div_Busy,
  output logic [3:0]                Wakeup_Valid,
  output logic [3:0]                Wakeup_RdType,
  output logic [4*PRF_W-1:0]        Wakeup_Prd
);
  localparam int IW = $clog2(REQ);
  localparam int CW = $clog2(DIV_LAT + 1);
`ifdef DIV_EARLY_WAKEUP_EN
  localparam logic [CW-1:0] DIV_FIRE = CW'(2);
`else
  localparam logic [CW-1:0] DIV_FIRE = CW'(1);
`endif
  typedef struct packed {
    logic             v;
    logic             we;
    logic             rt;
    logic [PRF_W-1:0] prd;
    logic [SPEC-1:0]  km;
  } op_t;
  logic [REQ-1:0] req_ok;
  logic [1:0]     gu;
  op_t            cap [4];
  op_t            mul_pipe [MUL_LAT-1];
  op_t            div_op;
  logic [CW-1:0]  div_cnt;
  logic           div_fire;
  // An in-flight op survives this cycle unless a mispredict hits one of its speculative tags
  function automatic logic live(op_t o);
    return o.v & ~(Kill_Enable & |(o.km & FUBR_SpecTag));
  endfunction
  // Kill first, then strip the resolved branch from the surviving mask
  function automatic op_t age(op_t o);
    op_t n;
    n = o;
    n.v = live(o);
    n.km = Update_KillMask ? o.km & ~FUBR_SpecTag : o.km;
    return n;
  endfunction
  assign Div_Busy = div_op.v;
  // Requests eligible for a grant: valid, not killed by a mispredict, and not blocked globally
  always_comb begin
    req_ok = '0;
    for (int r = 0; r < REQ; r++)
      req_ok[r] = Req_Valid[r] & ~(Kill_Enable & |(Req_KillMask[r*SPEC +: SPEC] & FUBR_SpecTag)) & ~(rst | Flush | Stall);
  end
  // Oldest-first scan; IALU requests fill IALU0 before IALU1, reserved type never matches a unit
  always_comb begin
    Issued_Valid = '0;
    FU_Issue_Valid = '0;
    FU_Issue_Idx = '0;
    gu = '0;
    for (int r = 0; r < REQ; r++) begin
      gu = Req_FuType[2*r +: 2] == 2'd0 ? {1'b0, FU_Issue_Valid[0]} : Req_FuType[2*r +: 2] == 2'd1 ? 2'd2 : 2'd3;
      if (req_ok[r] && Req_FuType[2*r +: 2] != 2'd3 && !FU_Issue_Valid[gu] && !(gu == 2'd3 && div_op.v)) begin
        FU_Issue_Valid[gu] = 1'b1;
        FU_Issue_Idx[gu*IW +: IW] = IW'(r);
        Issued_Valid[r] = 1'b1;
      end
    end
  end
  // Per-unit snapshot of the granted request, with a same-cycle mask update already applied
  always_comb begin
    for (int u = 0; u < 4; u++) begin
      cap[u].v   = FU_Issue_Valid[u];
      cap[u].we  = Req_RegWe[FU_Issue_Idx[u*IW +: IW]];
      cap[u].rt  = Req_RdType[FU_Issue_Idx[u*IW +: IW]];
      cap[u].prd = Req_Prd[FU_Issue_Idx[u*IW +: IW]*PRF_W +: PRF_W];
      cap[u].km  = Req_KillMask[FU_Issue_Idx[u*IW +: IW]*SPEC +: SPEC] & ~(Update_KillMask ? FUBR_SpecTag : '0);
    end
  end
  // The divider reports its result once the countdown reaches the wakeup point
  always_comb div_fire = live(div_op) && div_cnt == DIV_FIRE;
  // Tracking state and wakeup registers; wakeups already showing in a flush/reset cycle are unaffected
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      for (int s = 0; s < MUL_LAT - 1; s++) mul_pipe[s] <= '0;
      div_op        <= '0;
      div_cnt       <= '0;
      Wakeup_Valid  <= '0;
      Wakeup_RdType <= '0;
      Wakeup_Prd    <= '0;
    end else begin
      mul_pipe[0] <= cap[2];
      for (int s = 1; s < MUL_LAT - 1; s++) mul_pipe[s] <= age(mul_pipe[s-1]);
      div_op  <= cap[3].v ? cap[3] : (div_cnt == CW'(1) ? op_t'('0) : age(div_op));
      div_cnt <= cap[3].v ? CW'(DIV_LAT - 1) : (div_cnt != '0 ? div_cnt - 1'b1 : div_cnt);
      Wakeup_Valid  <= {div_fire & div_op.we, live(mul_pipe[MUL_LAT-2]) & mul_pipe[MUL_LAT-2].we,
                        live(cap[1]) & cap[1].we, live(cap[0]) & cap[0].we};
      Wakeup_RdType <= {div_op.rt, mul_pipe[MUL_LAT-2].rt, cap[1].rt, cap[0].rt};
      Wakeup_Prd    <= {div_op.prd, mul_pipe[MUL_LAT-2].prd, cap[1].prd, cap[0].prd};
    end
  end
endmodule

// File: tb/tb_int_issue_sched.sv
// tb_int_issue_sched: directed plus random stimulus against an op-list reference model of the issue scheduler
module tb_int_issue_sched;
  localparam int REQ = 4, PRF_W = 7, SPEC = 4, MUL_LAT = 3, DIV_LAT = 16;
`ifdef DIV_EARLY_WAKEUP_EN
  localparam int DIV_WAKE = DIV_LAT - 1;
`else
  localparam int DIV_WAKE = DIV_LAT;
`endif
  logic clk = 1'b0;
  logic rst, stall, flush, kill_en, upd_km;
  logic [SPEC-1:0] spec_tag;
  logic [REQ-1:0] req_v, req_we, req_rt;
  logic [2*REQ-1:0] req_ft;
  logic [REQ*PRF_W-1:0] req_prd;
  logic [REQ*SPEC-1:0] req_km;
  logic [REQ-1:0] issued;
  logic [3:0] fu_v, wk_v, wk_rt;
  logic [7:0] fu_idx;
  logic div_busy;
  logic [4*PRF_W-1:0] wk_prd;
  int n_tests = 0, n_fail = 0, cyc = 0, div_free = 0;
  typedef struct {
    int unit;
    int wake;
    bit we;
    bit rt;
    bit [PRF_W-1:0] prd;
    bit [SPEC-1:0] km;
  } m_op_t;
  m_op_t q[$];

  int_issue_sched #(.REQ(REQ), .PRF_W(PRF_W), .SPEC(SPEC), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .Stall(stall), .Flush(flush), .Kill_Enable(kill_en),
    .Update_KillMask(upd_km), .FUBR_SpecTag(spec_tag), .Req_Valid(req_v), .Req_FuType(req_ft),
    .Req_RegWe(req_we), .Req_RdType(req_rt), .Req_Prd(req_prd), .Req_KillMask(req_km),
    .Issued_Valid(issued), .FU_Issue_Valid(fu_v), .FU_Issue_Idx(fu_idx), .Div_Busy(div_busy),
    .Wakeup_Valid(wk_v), .Wakeup_RdType(wk_rt), .Wakeup_Prd(wk_prd)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr();
    stall = 0; flush = 0; kill_en = 0; upd_km = 0; spec_tag = '0;
    req_v = '0; req_ft = '0; req_we = '0; req_rt = '0; req_prd = '0; req_km = '0;
  endtask

  task automatic set_req(int r, int ft, bit we, bit rt, int prd, int km);
    req_v[r] = 1'b1;
    req_ft[2*r +: 2] = 2'(ft);
    req_we[r] = we;
    req_rt[r] = rt;
    req_prd[r*PRF_W +: PRF_W] = PRF_W'(prd);
    req_km[r*SPEC +: SPEC] = SPEC'(km);
  endtask

  // One cycle: sample at the falling edge, compare with the model, advance the model, cross the rising edge
  task automatic step();
    logic [3:0] e_fu, e_wv, e_wrt;
    logic [REQ-1:0] e_iss;
    logic [7:0] e_idx;
    logic [4*PRF_W-1:0] e_prd;
    int u, r;
    bit busy;
    m_op_t n;
    m_op_t keep[$];
    @(negedge clk);
    e_fu = '0; e_wv = '0; e_wrt = '0; e_iss = '0; e_idx = '0; e_prd = '0;
    foreach (q[i]) if (q[i].wake == cyc && q[i].we) begin
      e_wv[q[i].unit] = 1'b1;
      e_wrt[q[i].unit] = q[i].rt;
      e_prd[q[i].unit*PRF_W +: PRF_W] = q[i].prd;
    end
    busy = cyc < div_free;
    if (!(rst || flush || stall))
      for (r = 0; r < REQ; r++) begin
        if (!req_v[r] || (kill_en && (req_km[r*SPEC +: SPEC] & spec_tag) != 0)) continue;
        case (req_ft[2*r +: 2])
          2'd0: u = !e_fu[0] ? 0 : (!e_fu[1] ? 1 : -1);
          2'd1: u = !e_fu[2] ? 2 : -1;
          2'd2: u = (!e_fu[3] && !busy) ? 3 : -1;
          default: u = -1;
        endcase
        if (u >= 0) begin
          e_fu[u] = 1'b1;
          e_idx[2*u +: 2] = 2'(r);
          e_iss[r] = 1'b1;
        end
      end
    chk("issued_valid", 32'(issued), 32'(e_iss));
    chk("fu_issue_valid", 32'(fu_v), 32'(e_fu));
    chk("fu_issue_idx", 32'(fu_idx), 32'(e_idx));
    chk("div_busy", 32'(div_busy), 32'(busy));
    chk("wakeup_valid", 32'(wk_v), 32'(e_wv));
    for (int k = 0; k < 4; k++) if (e_wv[k]) begin
      chk($sformatf("wakeup_prd%0d", k), 32'(wk_prd[k*PRF_W +: PRF_W]), 32'(e_prd[k*PRF_W +: PRF_W]));
      chk($sformatf("wakeup_rdtype%0d", k), 32'(wk_rt[k]), 32'(e_wrt[k]));
    end
    foreach (q[i]) if (q[i].wake > cyc) keep.push_back(q[i]);
    q = keep;
    if (rst || flush) begin
      q = {};
      if (div_free > cyc + 1) div_free = cyc + 1;
    end else begin
      keep = {};
      foreach (q[i]) begin
        n = q[i];
        if (kill_en && (n.km & spec_tag) != 0) begin
          if (n.unit == 3 && div_free > cyc + 1) div_free = cyc + 1;
        end else begin
          if (upd_km) n.km = n.km & ~spec_tag;
          keep.push_back(n);
        end
      end
      q = keep;
      for (u = 0; u < 4; u++) if (e_fu[u]) begin
        r = int'(e_idx[2*u +: 2]);
        n.unit = u;
        n.wake = cyc + (u < 2 ? 1 : (u == 2 ? MUL_LAT : DIV_WAKE));
        n.we = req_we[r];
        n.rt = req_rt[r];
        n.prd = req_prd[r*PRF_W +: PRF_W];
        n.km = req_km[r*SPEC +: SPEC] & (upd_km ? ~spec_tag : {SPEC{1'b1}});
        q.push_back(n);
        if (u == 3) div_free = cyc + DIV_LAT;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    step();
    rst = 0;
    // three IALU requests: only two units exist
    set_req(0, 0, 1, 0, 'h11, 0); set_req(1, 0, 1, 1, 'h12, 0); set_req(2, 0, 1, 0, 'h13, 0);
    step();
    clr();
    repeat (2) step();
    // back-to-back MULs
    set_req(0, 1, 1, 0, 'h15, 0);
    step();
    set_req(0, 1, 1, 1, 'h16, 0);
    step();
    clr();
    repeat (4) step();
    // DIV request held: regrant when the divider frees
    set_req(0, 2, 1, 0, 'h20, 0);
    repeat (18) step();
    clr();
    repeat (17) step();
    // DIV killed mid-flight, new DIV right after
    set_req(0, 2, 1, 0, 'h21, 4'b0010);
    step();
    clr();
    repeat (4) step();
    kill_en = 1; spec_tag = 4'b0010;
    step();
    clr();
    set_req(0, 2, 1, 1, 'h22, 0);
    step();
    clr();
    repeat (17) step();
    // DIV survives a kill after its mask bit was resolved
    set_req(1, 2, 1, 0, 'h23, 4'b0010);
    step();
    clr();
    repeat (2) step();
    upd_km = 1; spec_tag = 4'b0010;
    step();
    clr();
    repeat (2) step();
    kill_en = 1; spec_tag = 4'b0010;
    step();
    clr();
    repeat (12) step();
    // stall with in-flight MUL, then flush, then normal grant
    set_req(0, 1, 1, 0, 'h30, 0);
    step();
    clr();
    stall = 1;
    set_req(0, 0, 1, 0, 'h31, 0); set_req(1, 0, 1, 0, 'h32, 0); set_req(2, 1, 1, 0, 'h33, 0); set_req(3, 2, 1, 0, 'h34, 0);
    repeat (2) step();
    clr();
    flush = 1;
    step();
    clr();
    set_req(0, 0, 1, 1, 'h35, 0);
    step();
    clr();
    repeat (2) step();
    // random traffic
    repeat (3000) begin
      req_v = 4'($urandom);
      req_ft = 8'($urandom);
      req_we = 4'($urandom | $urandom);
      req_rt = 4'($urandom);
      req_prd = 28'($urandom);
      req_km = 16'($urandom & $urandom);
      spec_tag = 4'(1 << $urandom_range(0, 3));
      kill_en = $urandom_range(0, 15) == 0;
      upd_km = $urandom_range(0, 7) == 0;
      stall = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 63) == 0;
      rst = $urandom_range(0, 127) == 0;
      step();
    end
    rst = 0;
    clr();
    repeat (DIV_LAT + 2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
